// File: rtl/bram_stream_reader.sv
// Plays back a contiguous run of block-RAM words as a valid/ready stream with a last flag.
// Define BRAM_STREAM_READER_LOOP_EN to replay the run continuously until stop.
module bram_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int                   DEPTH    = 4;
    localparam logic [ADDRESS_WIDTH:0] LEN_ZERO = '0;
    localparam logic [ADDRESS_WIDTH:0] LEN_ONE  = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    state_t                   state;
    logic [DATA_WIDTH-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0]         fifo_last;
    logic [1:0]               wr_ptr;
    logic [1:0]               rd_ptr;
    logic [2:0]               count;
    logic                     s1_valid, s1_last;
    logic                     s2_valid, s2_last;
    logic [ADDRESS_WIDTH-1:0] next_address;
    logic [ADDRESS_WIDTH:0]   remaining;
`ifdef BRAM_STREAM_READER_LOOP_EN
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH:0]   length_q;
`endif

    logic       push;
    logic       pop;
    logic [2:0] occupancy;
    logic       issue_ok;

    assign m_valid   = (count != 3'd0);
    assign m_data    = fifo_data[rd_ptr];
    assign m_last    = m_valid & fifo_last[rd_ptr];
    assign push      = s2_valid;
    assign pop       = m_valid & m_ready;
    // Words in the RAM pipeline are counted as already occupying FIFO space,
    // so a push can never find the FIFO full regardless of back-pressure.
    assign occupancy = count + {2'b00, s1_valid} + {2'b00, s2_valid};
    assign issue_ok  = (occupancy < 3'd4);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            read_address <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_data[i] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s2_valid     <= 1'b0;
            s2_last      <= 1'b0;
            next_address <= '0;
            remaining    <= '0;
`ifdef BRAM_STREAM_READER_LOOP_EN
            base_q       <= '0;
            length_q     <= '0;
`endif
        end else begin
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (push) begin
                fifo_data[wr_ptr] <= read_data;
                fifo_last[wr_ptr] <= s2_last;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (length == LEN_ZERO) begin
                            done <= 1'b1;
                        end else begin
                            // First read goes out on the start edge itself.
                            read_address <= base_address;
                            s1_valid     <= 1'b1;
                            s1_last      <= (length == LEN_ONE);
                            busy         <= 1'b1;
`ifdef BRAM_STREAM_READER_LOOP_EN
                            base_q       <= base_address;
                            length_q     <= length;
`endif
                            if (length == LEN_ONE) begin
`ifdef BRAM_STREAM_READER_LOOP_EN
                                next_address <= base_address;
                                remaining    <= length;
                                state        <= RUN;
`else
                                state        <= DRAIN;
`endif
                            end else begin
                                next_address <= base_address + ADDR_ONE;
                                remaining    <= length - LEN_ONE;
                                state        <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    if (issue_ok) begin
                        read_address <= next_address;
                        s1_valid     <= 1'b1;
                        s1_last      <= (remaining == LEN_ONE);
                        if (remaining == LEN_ONE) begin
`ifdef BRAM_STREAM_READER_LOOP_EN
                            next_address <= base_q;
                            remaining    <= length_q;
`else
                            state        <= DRAIN;
`endif
                        end else begin
                            next_address <= next_address + ADDR_ONE;
                            remaining    <= remaining - LEN_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_last[rd_ptr]) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (stop && state != IDLE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b0;
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end
        end
    end

endmodule
